fmul_op_dispatcher: RTL and testbench
=====================================

# fmul_op_dispatcher

Parametrised operation front end for the FMUL32 datapath. It accepts an encoded operation over a valid/ready handshake and decodes it to a one-hot issue vector of `OPERATION_NUM` bits. It holds the vector until the datapath accepts it, then enforces a multi-cycle occupancy window after every MUL. Codes at or above `OPERATION_NUM-1` mean IDLE: they are absorbed, never issued, and counted.

## Interface

Parameters:
- `OPERATION_NUM`, default 4: number of operations. Must be ≥ 2. The one-hot bit `OPERATION_NUM-1` is IDLE.
- `OP_W`, default `$clog2(OPERATION_NUM)`: operation code width.
- `MUL_LATENCY`, default 3: cycles the datapath is occupied per MUL, counted from the accepting handshake. Must be ≥ 1.
- `CNT_W`, default 8: width of the IDLE counter.

Ports:
- `clk`, input, 1: the only clock. All state changes on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `op_valid`, input, 1: an operation code is offered.
- `op`, input, `OP_W`: operation code. Code 0 is MUL.
- `op_ready`, output, 1: the dispatcher can take a code this cycle.
- `out_valid`, output, 1: `out_onehot` holds an issued operation.
- `out_ready`, input, 1: the datapath accepts the issued operation.
- `out_onehot`, output, `OPERATION_NUM`: decoded operation. Exactly one bit is set while `out_valid` is 1; all bits are 0 otherwise. Bit `OPERATION_NUM-1` is never set.
- `busy`, output, 1: a MUL occupancy window is active.
- `idle_cnt`, output, `CNT_W`: number of IDLE codes absorbed. Saturates.

## Operation

Decode:
- Code k with k < `OPERATION_NUM-1` sets one-hot bit k.
- Any code ≥ `OPERATION_NUM-1` is IDLE. This includes codes that do not fit the one-hot range when `OPERATION_NUM` is not a power of two.

The state machine has three states: EMPTY, HOLD and BUSY.

EMPTY
- `op_ready` is 1.
- `op_valid` with a non-IDLE code: register the one-hot vector and go to HOLD.
- `op_valid` with an IDLE code: stay in EMPTY and increment `idle_cnt`. `idle_cnt` holds at all-ones once it saturates.
- No `op_valid`: stay in EMPTY.

HOLD
- `op_ready` is 0 and `out_valid` is 1.
- `out_onehot` stays stable until the cycle in which `out_ready` is 1.
- On `out_ready`, if the held operation is MUL (bit 0) and `MUL_LATENCY` > 1: load the down-counter with `MUL_LATENCY-1` and go to BUSY.
- On `out_ready` in every other case: go to EMPTY.
- Without `out_ready`: stay in HOLD indefinitely.

BUSY
- `op_ready`, `out_valid` and `out_onehot` are all 0. `busy` is 1.
- The down-counter decrements every cycle.
- When the counter is 1, the next state is EMPTY.
- The counter width is `$clog2(MUL_LATENCY)`, with a minimum of 1.

Other rules:
- `op` is ignored unless `op_valid` and `op_ready` are both 1. `out_ready` is ignored outside HOLD.
- The dispatcher holds one operation at a time. There is no queue.
- Reset applied in any state aborts the operation. A held operation or an active BUSY window is discarded.

## Timing

Reset values, while `rst_n` = 0 and in the first cycle after it is released:
- state = EMPTY
- `out_valid` = 0
- `out_onehot` = 0
- `busy` = 0
- `idle_cnt` = 0
- `op_ready` = 0 while `rst_n` = 0, then 1 after reset is released

Handshake timing:
- `op_ready` is a registered-state decode, with no combinational path from `op_valid`.
- `out_valid` is registered.
- An operation accepted at edge N drives `out_valid` = 1 from cycle N+1. The issue latency is therefore 1 cycle.
- If `out_ready` is already 1 in the first HOLD cycle, the issue is accepted that cycle.
- A non-MUL operation gives `op_ready` = 1 again in the cycle after acceptance. The steady-state rate with `out_ready` tied to 1 is one operation per 2 cycles.
- A MUL accepted by the datapath at edge M holds `busy` = 1 for cycles M+1 … M+`MUL_LATENCY`-1. `op_ready` returns to 1 at cycle M+`MUL_LATENCY`.
- An IDLE code is absorbed in one cycle. `op_ready` stays 1, so IDLE codes can arrive every cycle.
- `idle_cnt` updates on the edge that absorbs the code.

## Test plan

- Reset: hold `rst_n` = 0 for 3 cycles with `op_valid` = 1 and `op` = 1. During reset, `op_ready` = 0, `out_valid` = 0 and `idle_cnt` = 0. In the first cycle after release, `op_ready` = 1.
- Decode sweep, `OPERATION_NUM` = 4, `out_ready` = 1: send codes 1 and 2. `out_onehot` shows 0010 and then 0100, each asserted for exactly one cycle, with one EMPTY cycle between them.
- MUL window, `MUL_LATENCY` = 3: send code 0 while `out_ready` = 1. `out_onehot` = 0001 for one cycle, then `busy` = 1 for 2 cycles, then `op_ready` = 1.
- Backpressure: send code 2 with `out_ready` = 0 for 5 cycles. `out_valid` = 1 and `out_onehot` = 0100 stay stable. `op_ready` = 0 throughout, and an `op_valid` offered during this time is not taken. Raise `out_ready`: the issue completes in that cycle.
- IDLE saturation, `CNT_W` = 2, `OPERATION_NUM` = 5, `OP_W` = 3: send codes 4, 7, 5, 6, 4 back to back. `out_valid` stays 0 and `idle_cnt` reads 1, 2, 3, 3, 3.
- Reset mid-BUSY, `MUL_LATENCY` = 8: issue a MUL and assert `rst_n` = 0 in the second BUSY cycle. `busy` = 0 and the state is EMPTY after reset, and the next code 1 issues normally.

Source files
------------

// File: rtl/fmul_op_dispatcher.sv
// rtl/fmul_op_dispatcher.sv - FMUL32 operation front end: decode, issue hold and MUL occupancy window
module fmul_op_dispatcher #(
    parameter int OPERATION_NUM = 4,
    parameter int OP_W          = $clog2(OPERATION_NUM),
    parameter int MUL_LATENCY   = 3,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    input  logic [OP_W-1:0]          op,
    output logic                     op_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERATION_NUM-1:0] out_onehot,
    output logic                     busy,
    output logic [CNT_W-1:0]         idle_cnt
);

    // Occupancy counter must hold MUL_LATENCY-1; keep at least one bit for MUL_LATENCY of 1 or 2.
    localparam int LAT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                   state;
    logic [LAT_W-1:0]         lat_cnt;
    logic [31:0]              op_ext;
    logic                     op_is_idle;
    logic [OPERATION_NUM-1:0] op_dec;

    assign op_ext     = 32'(op);
    // Codes past the one-hot range (non power-of-two OPERATION_NUM) are IDLE as well.
    assign op_is_idle = (op_ext >= 32'(OPERATION_NUM - 1));

    // Decode the incoming code to a one-hot vector; the IDLE bit is never produced here.
    always_comb begin
        op_dec = '0;
        for (int k = 0; k < OPERATION_NUM - 1; k++) begin
            if (op_ext == 32'(k)) begin
                op_dec[k] = 1'b1;
            end
        end
    end

    // Dispatcher state machine; every output is a register so nothing depends combinationally on op_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            op_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            busy       <= 1'b0;
            lat_cnt    <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        if (op_is_idle) begin
                            if (idle_cnt != '1) begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end else begin
                            out_onehot <= op_dec;
                            out_valid  <= 1'b1;
                            op_ready   <= 1'b0;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_onehot <= '0;
                        if (out_onehot[0] && (MUL_LATENCY > 1)) begin
                            lat_cnt  <= LAT_W'(MUL_LATENCY - 1);
                            busy     <= 1'b1;
                            op_ready <= 1'b0;
                            state    <= BUSY;
                        end else begin
                            op_ready <= 1'b1;
                            state    <= EMPTY;
                        end
                    end
                end
                BUSY: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        busy     <= 1'b0;
                        op_ready <= 1'b1;
                        state    <= EMPTY;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    op_ready   <= 1'b0;
                    out_valid  <= 1'b0;
                    out_onehot <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_op_dispatcher.sv
// tb/tb_fmul_op_dispatcher.sv - directed bench for fmul_op_dispatcher
module tb_fmul_op_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // default instance: 4 operations, MUL latency 3
    logic       rst_n;
    logic       a_op_valid, a_out_ready;
    logic [1:0] a_op;
    logic       a_op_ready, a_out_valid, a_busy;
    logic [3:0] a_out_onehot;
    logic [7:0] a_idle_cnt;

    // IDLE saturation instance: 5 operations, 3-bit codes, 2-bit counter
    logic       b_op_valid, b_out_ready;
    logic [2:0] b_op;
    logic       b_op_ready, b_out_valid, b_busy;
    logic [4:0] b_out_onehot;
    logic [1:0] b_idle_cnt;

    // long MUL instance: latency 8, own reset
    logic       c_rst_n;
    logic       c_op_valid, c_out_ready;
    logic [1:0] c_op;
    logic       c_op_ready, c_out_valid, c_busy;
    logic [3:0] c_out_onehot;
    logic [7:0] c_idle_cnt;

    fmul_op_dispatcher u_dut (
        .clk(clk), .rst_n(rst_n), .op_valid(a_op_valid), .op(a_op), .op_ready(a_op_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
        .busy(a_busy), .idle_cnt(a_idle_cnt)
    );

    fmul_op_dispatcher #(.OPERATION_NUM(5), .OP_W(3), .MUL_LATENCY(3), .CNT_W(2)) u_idle (
        .clk(clk), .rst_n(rst_n), .op_valid(b_op_valid), .op(b_op), .op_ready(b_op_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
        .busy(b_busy), .idle_cnt(b_idle_cnt)
    );

    fmul_op_dispatcher #(.OPERATION_NUM(4), .MUL_LATENCY(8)) u_mul8 (
        .clk(clk), .rst_n(c_rst_n), .op_valid(c_op_valid), .op(c_op), .op_ready(c_op_ready),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_onehot(c_out_onehot),
        .busy(c_busy), .idle_cnt(c_idle_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idle[5];
        int idle_codes[5];
        exp_idle   = '{1, 2, 3, 3, 3};
        idle_codes = '{4, 7, 5, 6, 4};

        rst_n = 1'b0; c_rst_n = 1'b0;
        a_op_valid = 1'b1; a_op = 2'd1; a_out_ready = 1'b0;
        b_op_valid = 1'b0; b_op = 3'd0; b_out_ready = 1'b1;
        c_op_valid = 1'b0; c_op = 2'd0; c_out_ready = 1'b1;

        // reset held for 3 cycles with a code offered
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_op_ready", a_op_ready, 0);
            check("rst_out_valid", a_out_valid, 0);
            check("rst_idle_cnt", a_idle_cnt, 0);
        end
        rst_n = 1'b1; c_rst_n = 1'b1;
        a_op_valid = 1'b0;
        tick();
        check("post_rst_op_ready", a_op_ready, 1);
        check("post_rst_out_valid", a_out_valid, 0);
        check("post_rst_onehot", a_out_onehot, 0);
        check("post_rst_busy", a_busy, 0);

        // decode sweep: codes 1 and 2 with out_ready tied high
        a_out_ready = 1'b1;
        a_op_valid = 1'b1; a_op = 2'd1;
        tick();
        a_op = 2'd2;
        check("dec1_onehot", a_out_onehot, 4'b0010);
        check("dec1_valid", a_out_valid, 1);
        check("dec1_ready", a_op_ready, 0);
        tick();
        check("gap_valid", a_out_valid, 0);
        check("gap_onehot", a_out_onehot, 0);
        check("gap_ready", a_op_ready, 1);
        tick();
        a_op_valid = 1'b0;
        check("dec2_onehot", a_out_onehot, 4'b0100);
        tick();
        check("dec2_done_valid", a_out_valid, 0);

        // MUL window of latency 3
        a_op_valid = 1'b1; a_op = 2'd0;
        tick();
        a_op_valid = 1'b0;
        check("mul_onehot", a_out_onehot, 4'b0001);
        check("mul_busy_hold", a_busy, 0);
        tick();
        check("mul_busy1", a_busy, 1);
        check("mul_busy1_ready", a_op_ready, 0);
        check("mul_busy1_valid", a_out_valid, 0);
        tick();
        check("mul_busy2", a_busy, 1);
        check("mul_busy2_ready", a_op_ready, 0);
        tick();
        check("mul_end_busy", a_busy, 0);
        check("mul_end_ready", a_op_ready, 1);

        // backpressure: code 2 held for 5 cycles while another code is offered
        a_out_ready = 1'b0;
        a_op_valid = 1'b1; a_op = 2'd2;
        tick();
        a_op = 2'd1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", a_out_valid, 1);
            check("bp_onehot", a_out_onehot, 4'b0100);
            check("bp_ready", a_op_ready, 0);
            tick();
        end
        a_op_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("bp_done_valid", a_out_valid, 0);
        check("bp_done_onehot", a_out_onehot, 0);
        check("bp_done_ready", a_op_ready, 1);

        // IDLE codes back to back saturate a 2-bit counter
        b_op_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_op = 3'(idle_codes[i]);
            tick();
            check("idle_cnt", b_idle_cnt, exp_idle[i]);
            check("idle_valid", b_out_valid, 0);
            check("idle_ready", b_op_ready, 1);
        end
        b_op_valid = 1'b0;

        // reset during the second BUSY cycle of a latency-8 MUL
        c_op_valid = 1'b1; c_op = 2'd0;
        tick();
        c_op_valid = 1'b0;
        check("m8_onehot", c_out_onehot, 4'b0001);
        tick();
        check("m8_busy1", c_busy, 1);
        tick();
        check("m8_busy2", c_busy, 1);
        c_rst_n = 1'b0;
        tick();
        check("m8_rst_busy", c_busy, 0);
        check("m8_rst_valid", c_out_valid, 0);
        c_rst_n = 1'b1;
        tick();
        check("m8_after_busy", c_busy, 0);
        check("m8_after_ready", c_op_ready, 1);
        c_op_valid = 1'b1; c_op = 2'd1;
        tick();
        c_op_valid = 1'b0;
        check("m8_next_onehot", c_out_onehot, 4'b0010);
        check("m8_next_valid", c_out_valid, 1);
        tick();
        check("m8_next_done", c_out_valid, 0);
        check("m8_next_nobusy", c_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
